// File: rtl/alarm_clock_core.sv
// Time-of-day engine: hh:mm:ss counter, four display modes, N hh:mm alarms with ring/auto-silence.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_clock_core #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned N_ALARMS     = 2,
  parameter int unsigned RING_SECONDS = 60,
  parameter int unsigned SNOOZE_MIN   = 9,
  localparam int unsigned AW          = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                CLK100MHZ,
  input  logic                reset,
  input  logic                mode_bttn,
  input  logic [1:0]          position,
  input  logic                add,
  input  logic                sub,
  input  logic [AW-1:0]       alarm_sel,
  input  logic [N_ALARMS-1:0] alarm_en,
  input  logic                dismiss,
  input  logic                snooze,
  output logic [1:0]          current_mode,
  output logic [7:0]          disp_hours,
  output logic [7:0]          disp_minutes,
  output logic [7:0]          disp_seconds,
  output logic                am_pm,
  output logic [N_ALARMS-1:0] ringing,
  output logic                sec_tick
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {Mode24h = 2'b00, ModeSet = 2'b01, ModeAlarm = 2'b10, Mode12h = 2'b11}
    mode_e;

  mode_e                    mode_q, mode_d;
  logic [PW-1:0]            presc_q, presc_d;
  logic [5:0]               hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [N_ALARMS-1:0][5:0] al_h_q, al_h_d, al_m_q, al_m_d;
  logic [N_ALARMS-1:0]      ring_q, ring_d;
  logic [N_ALARMS-1:0][7:0] cnt_q, cnt_d;
  logic                     tick_q;
  logic [1:0]               cur_mode_q;
  logic [7:0]               dh_q, dm_q, ds_q;
  logic                     pm_q;

  logic       tick, edit_up, edit_dn, edit;
  logic [5:0] nh, nm, ns;
  logic [AW-1:0] sel;
  logic [5:0] dh, dm, ds;

`ifdef ALARM_SNOOZE_EN
  logic [N_ALARMS-1:0]      snz_q, snz_d;
  logic [N_ALARMS-1:0][5:0] snz_h_q, snz_h_d, snz_m_q, snz_m_d;
  logic [6:0]               tgt_m;
  logic [5:0]               tgt_h;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] lim,
                                           input logic up, input logic dn);
    logic [5:0] r;
    r = v;
    if (up && !dn) r = (v == lim - 6'd1) ? 6'd0 : v + 6'd1;
    else if (dn && !up) r = (v == 6'd0) ? lim - 6'd1 : v - 6'd1;
    return r;
  endfunction

  always_comb begin
    mode_d = mode_q;
    if (mode_bttn) begin
      unique case (mode_q)
        Mode24h:   mode_d = ModeSet;
        ModeSet:   mode_d = ModeAlarm;
        ModeAlarm: mode_d = Mode12h;
        Mode12h:   mode_d = Mode24h;
        default:   mode_d = Mode24h;
      endcase
    end

    tick    = (mode_q != ModeSet) && (presc_q == PrescMax);
    presc_d = (mode_q == ModeSet || tick) ? '0 : presc_q + 1'b1;

    // A mode press swallows any simultaneous edit.
    edit_up = add & ~sub & ~mode_bttn;
    edit_dn = sub & ~add & ~mode_bttn;
    edit    = edit_up | edit_dn;

    sel = (32'(alarm_sel) >= N_ALARMS) ? '0 : alarm_sel;

    ns = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
    nm = min_q;
    nh = hour_q;
    if (sec_q == 6'd59) begin
      nm = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      if (min_q == 6'd59) nh = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
    end

    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    if (tick) begin
      hour_d = nh;
      min_d  = nm;
      sec_d  = ns;
    end else if (mode_q == ModeSet) begin
      case (position)
        2'b00:   hour_d = wrap_step(hour_q, 6'd24, edit_up, edit_dn);
        2'b01:   min_d  = wrap_step(min_q, 6'd60, edit_up, edit_dn);
        2'b10:   sec_d  = wrap_step(sec_q, 6'd60, edit_up, edit_dn);
        default: ;
      endcase
    end

`ifdef ALARM_SNOOZE_EN
    tgt_m = {1'b0, min_q} + 7'(SNOOZE_MIN);
    tgt_h = hour_q;
    if (tgt_m >= 7'd60) begin
      tgt_m = tgt_m - 7'd60;
      tgt_h = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
    end
    snz_d   = snz_q;
    snz_h_d = snz_h_q;
    snz_m_d = snz_m_q;
`endif

    al_h_d = al_h_q;
    al_m_d = al_m_q;
    ring_d = ring_q;
    cnt_d  = cnt_q;
    dh     = hour_q;
    dm     = min_q;
    ds     = sec_q;
    for (int i = 0; i < int'(N_ALARMS); i++) begin
      if (mode_q == ModeAlarm && AW'(i) == sel) begin
        dh = al_h_q[i];
        dm = al_m_q[i];
        ds = 6'd0;
        if (edit && !position[1]) begin
          if (position[0]) al_m_d[i] = wrap_step(al_m_q[i], 6'd60, edit_up, edit_dn);
          else             al_h_d[i] = wrap_step(al_h_q[i], 6'd24, edit_up, edit_dn);
`ifdef ALARM_SNOOZE_EN
          snz_d[i] = 1'b0;
`endif
        end
      end

      if (tick && ring_q[i]) begin
        if ({1'b0, cnt_q[i]} + 9'd1 >= 9'(RING_SECONDS)) ring_d[i] = 1'b0;
        else cnt_d[i] = cnt_q[i] + 8'd1;
      end
      if (tick && alarm_en[i] && ns == 6'd0 && nm == al_m_q[i] && nh == al_h_q[i]) begin
        ring_d[i] = 1'b1;
        cnt_d[i]  = 8'd0;
      end
`ifdef ALARM_SNOOZE_EN
      if (tick && snz_q[i] && ns == 6'd0 && nm == snz_m_q[i] && nh == snz_h_q[i]) begin
        ring_d[i] = 1'b1;
        cnt_d[i]  = 8'd0;
        snz_d[i]  = 1'b0;
      end
      if (snooze && ring_q[i]) begin
        ring_d[i]  = 1'b0;
        snz_d[i]   = 1'b1;
        snz_h_d[i] = tgt_h;
        snz_m_d[i] = tgt_m[5:0];
      end
      if (dismiss || !alarm_en[i]) snz_d[i] = 1'b0;
`endif
      if (dismiss || !alarm_en[i]) ring_d[i] = 1'b0;
    end

    if (mode_q == Mode12h) begin
      if (dh == 6'd0) dh = 6'd12;
      else if (dh > 6'd12) dh = dh - 6'd12;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      mode_q     <= Mode24h;
      presc_q    <= '0;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      al_h_q     <= '0;
      al_m_q     <= '0;
      ring_q     <= '0;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      cur_mode_q <= 2'b00;
      dh_q       <= '0;
      dm_q       <= '0;
      ds_q       <= '0;
      pm_q       <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      al_h_q     <= al_h_d;
      al_m_q     <= al_m_d;
      ring_q     <= ring_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick;
      cur_mode_q <= mode_q;
      dh_q       <= {2'b00, dh};
      dm_q       <= {2'b00, dm};
      ds_q       <= {2'b00, ds};
      // PM is judged on the 24-hour value, before the 12-hour remap.
      pm_q       <= (mode_q == ModeAlarm) ? (dh >= 6'd12) : (hour_q >= 6'd12);
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      snz_q   <= '0;
      snz_h_q <= '0;
      snz_m_q <= '0;
    end else begin
      snz_q   <= snz_d;
      snz_h_q <= snz_h_d;
      snz_m_q <= snz_m_d;
    end
  end
`endif

  assign current_mode = cur_mode_q;
  assign disp_hours   = dh_q;
  assign disp_minutes = dm_q;
  assign disp_seconds = ds_q;
  assign am_pm        = pm_q;
  assign ringing      = ring_q;
  assign sec_tick     = tick_q;

endmodule

// File: doc/alarm_clock_core.md
# alarm_clock_core

Parametrised time-of-day engine for the board clock: keeps hh:mm:ss from the system clock, supports four display modes (24-hour, set-time, set-alarm, 12-hour), and adds N independent hh:mm alarms with ringing, auto-silence and optional snooze. It sits between the debouncers and the BCD/seven-segment path. It replaces the separate counter, set-time, mode and 12-hour pieces with one registered block.

## Interface
- CLK_HZ, 100_000_000, input clock cycles per second.
- N_ALARMS, 2, number of alarm channels, 1..8; AW = max(1, clog2(N_ALARMS)).
- RING_SECONDS, 60, ring auto-silence time, 1..255.
- SNOOZE_MIN, 9, snooze delay in minutes, 1..59.
- CLK100MHZ in 1: the single clock.
- reset in 1: asynchronous, active-high.
- mode_bttn in 1: debounced one-cycle pulse; advances the mode.
- position in 2: field select. 00 = hours, 01 = minutes, 10 = seconds, 11 = none.
- add, sub in 1: debounced one-cycle pulses that increment or decrement the selected field.
- alarm_sel in AW: selects the alarm to edit or display; values ≥ N_ALARMS select alarm 0.
- alarm_en in N_ALARMS: per-alarm arm, level.
- dismiss in 1: pulse; clears all ringing.
- snooze in 1: pulse; used only with ALARM_SNOOZE_EN.
- current_mode out 2: 00 = 24H, 01 = SET, 10 = ALARM, 11 = 12H.
- disp_hours, disp_minutes, disp_seconds out 8 each: binary, ready for BCD.
- am_pm out 1: 1 = PM (displayed 24-hour value ≥ 12).
- ringing out N_ALARMS: per-alarm ring.
- sec_tick out 1: one-cycle pulse on each counted second.

## Operation
- **Mode FSM.** Order is 24H→SET→ALARM→12H→24H, one step per mode_bttn pulse.
  - A mode press in the same cycle as add or sub: the mode changes and the edit is dropped.
- **Prescaler.** Counts 0..CLK_HZ-1. sec_tick fires when the count is CLK_HZ-1.
  - On tick: seconds, minutes and hours carry with wrap at 59:59 and 23:59:59 → 00:00:00.
- **SET mode.**
  - Prescaler held at 0; time frozen; sec_tick is 0.
  - add/sub edit the live time field selected by position, modulo 24/60/60. No carry into neighbouring fields.
  - add and sub together: no change.
- **ALARM mode.**
  - Time keeps running.
  - add/sub edit the hours or minutes of alarm[alarm_sel], modulo 24/60. position 10 or 11 makes no edit.
  - An edit cancels any pending snooze for that alarm.
- **Display select.**
  - 24H: live time.
  - SET: live time.
  - ALARM: alarm[alarm_sel] hh:mm with seconds shown as 0.
  - 12H: live time with hours mapped 0→12, 1..12 unchanged, 13..23→h-12.
  - am_pm is always derived from the 24-hour value of the displayed hours.
- **Alarm match.** Evaluated only on a tick. If alarm_en[i] is high and the next time equals alarm[i]:00, ringing[i] sets on the same edge the time updates.
  - Editing the time to hh:mm:00 does not trigger a match.
- **Ring clear.** Highest priority first:
  1. reset;
  2. alarm_en[i] low;
  3. dismiss;
  4. the per-alarm ring counter reaching RING_SECONDS ticks after set.
- **Re-trigger.** A match on an already-ringing alarm restarts its ring counter.

## Timing
- **Reset values.**
  - Time 00:00:00.
  - All alarms 00:00.
  - Mode 00.
  - ringing 0, sec_tick 0, snooze state cleared.
  - disp_* 0, am_pm 0.
- **Latency.** All outputs are registered.
  - disp_*, am_pm and current_mode reflect a state change one cycle after the edge that made it.
  - ringing and sec_tick are direct register outputs with no extra latency.
- **First second.** The first tick after reset, or after leaving SET, occurs CLK_HZ cycles later.
- **Input pulses.** One edit per input pulse. Pulses longer than one cycle are an upstream error; each high cycle counts.
- **Reset mid-operation.** Asynchronous assert clears everything immediately, including an active ring and a mode in progress.
- **Reset release.** Synchronous to the next edge.

## Configuration
- **ALARM_SNOOZE_EN defined.**
  - A snooze pulse while any ringing[i] is high clears those rings.
  - Each such alarm's snooze target is loaded with the current hh:mm + SNOOZE_MIN, with hour and day wrap.
  - The target matches like an alarm, once, then clears. dismiss or alarm_en[i] low also clears it.
- **ALARM_SNOOZE_EN undefined.**
  - The snooze input is ignored and no snooze registers are built.
  - All other behaviour is identical.

## Test plan
1. CLK_HZ=10: reset then 10 cycles → sec_tick high once, disp_seconds=1; from 23:59:59 one tick → 00:00:00.
2. Four mode_bttn pulses → current_mode 01,10,11,00. In SET, position=01 and add at minutes=59 → 00 with hours unchanged; add+sub together → no change.
3. 12H mode at hours 0, 12, 13 → disp_hours 12/am_pm 0, 12/1, 1/1.
4. Alarm 1 = 07:30, alarm_en=2'b10, time 07:29:59, one tick → ringing=2'b10 on the same edge. After RING_SECONDS=3 further ticks → 0. Repeat with dismiss → cleared next cycle.
5. Snooze build with SNOOZE_MIN=9, ringing at 07:30, snooze pulse → ringing 0, then ringing again at 07:39:00. Non-snooze build: snooze has no effect.
6. Assert reset while ringing in ALARM mode → all outputs at reset values, current_mode 00.
